// File: rtl/su_fetch_seq_if.sv
// su_fetch_seq_if: instruction-memory read handshake plus the ISA-decoder strobe/byte bus.
// master = sequencer side, slave = memory/decoder side.
interface su_fetch_seq_if;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       fetch;
    logic       ce_n;
    logic [7:0] insr;

    modport master (
        output mem_req, fetch, ce_n, insr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, fetch, ce_n, insr,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/su_fetch_seq.sv
// su_fetch_seq: IDLE/FETCH/WAIT/EXEC instruction fetch sequencer feeding an ISA decoder.
// Optional fetch-timeout watchdog enabled by defining SU_FETCH_TIMEOUT_EN.
module su_fetch_seq #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    su_fetch_seq_if.master        bus,
    input  logic                  run,
    input  logic                  stall,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic [15:0]           icount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        EXEC  = 2'd3
    } state_t;

    localparam logic [7:0] HLT = 8'hFF;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("su_fetch_seq: TIMEOUT_CYC must be within 1..255");
    end

    state_t      state_q, state_d;
    logic [7:0]  insr_q, insr_d;
    logic        halted_q, halted_d;
    logic [15:0] icount_q, icount_d;
    logic        tmo_hit;
    logic        fault_q;

`ifdef SU_FETCH_TIMEOUT_EN
    // Counter holds the number of ack-less WAIT cycles already elapsed, so the
    // terminal cycle is the one where it still reads TIMEOUT_CYC-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wcnt_q, wcnt_d;
    logic       fault_d;

    assign tmo_hit = (wcnt_q == TMO_LAST);

    always_comb begin
        wcnt_d  = wcnt_q;
        fault_d = fault_q;
        case (state_q)
            IDLE:    if (!run) fault_d = 1'b0;
            FETCH:   wcnt_d = 8'd0;
            WAIT: begin
                if (!bus.mem_ack) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (tmo_hit) fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            fault_q <= fault_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign fault_q = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        insr_d   = insr_q;
        halted_d = halted_q;
        icount_d = icount_q;
        case (state_q)
            IDLE: begin
                // run=0 in IDLE is the acknowledge that clears sticky status
                if (!run)
                    halted_d = 1'b0;
                else if (!halted_q && !fault_q)
                    state_d = FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // ack beats a simultaneous terminal count
                if (bus.mem_ack) begin
                    insr_d  = bus.mem_rdata;
                    state_d = EXEC;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (!stall) begin
                    icount_d = icount_q + 16'd1;
                    if (insr_q == HLT) begin
                        halted_d = 1'b1;
                        state_d  = IDLE;
                    end else if (run) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            insr_q   <= 8'h00;
            halted_q <= 1'b0;
            icount_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            insr_q   <= insr_d;
            halted_q <= halted_d;
            icount_q <= icount_d;
        end
    end

    // Decoder/memory strobes depend on the state register only.
    assign bus.fetch   = (state_q == FETCH);
    assign bus.ce_n    = !((state_q == FETCH) || (state_q == EXEC));
    assign bus.mem_req = (state_q == FETCH) || (state_q == WAIT);
    assign bus.insr    = insr_q;

    assign busy   = (state_q != IDLE);
    assign halted = halted_q;
    assign fault  = fault_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_su_fetch_seq.sv
// tb_su_fetch_seq: directed scenarios plus randomized traffic against an instruction-level model.
// Expectations for the timeout scenario follow SU_FETCH_TIMEOUT_EN.
module tb_su_fetch_seq;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n, run, stall, busy, halted, fault;
  logic [15:0] icount;
  su_fetch_seq_if bus();

  su_fetch_seq #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .run(run), .stall(stall),
    .busy(busy), .halted(halted), .fault(fault), .icount(icount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: an instruction in flight is "active"; its first cycle is the fetch
  // strobe, then it waits for a byte, then it executes that byte
  bit          m_active, m_fetch_now, m_have, m_halted, m_fault;
  logic [7:0]  m_insr;
  logic [15:0] m_icount;
  int          m_wc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_fetch_now = 0; m_have = 0; m_halted = 0; m_fault = 0;
    m_insr = 8'h00; m_icount = 16'h0000; m_wc = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin model_reset(); return; end
    if (!m_active) begin
      if (!run) begin m_halted = 0; m_fault = 0; end
      else if (!m_halted && !m_fault) begin m_active = 1; m_fetch_now = 1; m_have = 0; end
    end else if (m_fetch_now) begin
      m_fetch_now = 0; m_wc = 0;
    end else if (!m_have) begin
      if (bus.mem_ack) begin m_insr = bus.mem_rdata; m_have = 1; end
      else begin
        m_wc++;
`ifdef SU_FETCH_TIMEOUT_EN
        if (m_wc == TMO) begin m_fault = 1; m_active = 0; end
`endif
      end
    end else if (!stall) begin
      m_icount++;
      m_have = 0;
      if (m_insr == 8'hFF) begin m_halted = 1; m_active = 0; end
      else if (run) m_fetch_now = 1;
      else m_active = 0;
    end
  endtask

  task automatic check_all();
    chk("fetch",   bus.fetch,   m_active && m_fetch_now);
    chk("ce_n",    bus.ce_n,    !(m_active && (m_fetch_now || m_have)));
    chk("mem_req", bus.mem_req, m_active && !m_have);
    chk("busy",    busy,        m_active);
    chk("halted",  halted,      m_halted);
    chk("fault",   fault,       m_fault);
    chk("insr",    bus.insr,    m_insr);
    chk("icount",  icount,      m_icount);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_icount_ffff();
    force dut.icount_q = 16'hFFFF;
    m_icount = 16'hFFFF;
    @(negedge clk);
    release dut.icount_q;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [3];
    int n;
    seq[0] = 8'h10; seq[1] = 8'hA3; seq[2] = 8'hFF;

    rst_n = 1'b0; run = 1'b0; stall = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    model_reset();
    #2;
    check_all();
    chk("rst_ce_n", bus.ce_n, 1);
    chk("rst_icount", icount, 0);
    tick();
    rst_n = 1'b1;

    // single instruction, ack in first WAIT cycle (ack during FETCH is ignored)
    run = 1'b1;
    tick();
    chk("t31_fetch", bus.fetch, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h81;
    tick();
    chk("t31_fetch_pulse", bus.fetch, 0);
    tick();
    chk("t31_insr", bus.insr, 8'h81);
    chk("t31_ce_n", bus.ce_n, 0);
    run = 1'b0; bus.mem_ack = 1'b0;
    tick();
    chk("t31_icount", icount, 1);

    // three back-to-back instructions ending in HLT
    do_reset();
    run = 1'b1; bus.mem_ack = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t32_fetch", bus.fetch, 1);
      bus.mem_rdata = seq[k];
      tick();
      tick();
      chk("t32_insr", bus.insr, seq[k]);
      tick();
    end
    chk("t32_halted", halted, 1);
    chk("t32_busy", busy, 0);
    chk("t32_icount", icount, 3);
    tick();
    chk("t32_no_req", bus.mem_req, 0);
    run = 1'b0; bus.mem_ack = 1'b0;
    tick();
    chk("t32_halt_clr", halted, 0);

    // stall held in EXEC
    do_reset();
    run = 1'b1;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h05;
    tick();
    stall = 1'b1;
    tick();
    bus.mem_ack = 1'b0; run = 1'b0;
    n = 0;
    while (!bus.ce_n && !bus.fetch && n < 20) begin
      n++;
      chk("t33_insr", bus.insr, 8'h05);
      stall = (n < 5);
      tick();
    end
    chk("t33_exec_cycles", n, 5);
    chk("t33_icount", icount, 1);
    stall = 1'b0;

    // run dropped during WAIT; instruction still retires
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h3C;
    tick();
    bus.mem_ack = 1'b0;
    chk("t34_insr", bus.insr, 8'h3C);
    tick();
    chk("t34_icount", icount, 1);
    chk("t34_busy", busy, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) n++;
      tick();
    end
    chk("t34_no_req", n, 0);

    // no ack at all
    do_reset();
    run = 1'b1;
    tick();
    tick();
`ifdef SU_FETCH_TIMEOUT_EN
    n = 0;
    while (bus.mem_req && !bus.fetch && n < 40) begin
      n++;
      tick();
    end
    chk("t35_wait_cycles", n, TMO);
    chk("t35_fault", fault, 1);
    chk("t35_req_drop", bus.mem_req, 0);
    tick();
    chk("t35_fault_hold", bus.mem_req, 0);
    run = 1'b0;
    tick();
    chk("t35_fault_clr", fault, 0);
    run = 1'b1;
    tick();
    chk("t35_resume", bus.fetch, 1);
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      chk("t35_req_held", bus.mem_req, 1);
      chk("t35_no_fault", fault, 0);
      tick();
    end
`endif
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11; run = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    tick();

    // wrap, then reset in EXEC just before another wrap
    do_reset();
    set_icount_ffff();
    run = 1'b1;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h22;
    tick();
    tick();
    run = 1'b0; bus.mem_ack = 1'b0;
    tick();
    chk("t36_wrap", icount, 16'h0000);
    set_icount_ffff();
    run = 1'b1;
    tick();
    bus.mem_ack = 1'b1;
    tick();
    stall = 1'b1; bus.mem_ack = 1'b0;
    tick();
    chk("t36_exec_icount", icount, 16'hFFFF);
    run = 1'b0;
    do_reset();
    chk("t36_rst_icount", icount, 16'h0000);
    chk("t36_rst_busy", busy, 0);
    chk("t36_rst_insr", bus.insr, 8'h00);
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req) n++;
      tick();
    end
    chk("t36_no_refetch", n, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      stall = ($urandom_range(0, 3) == 0);
      bus.mem_ack = ($urandom_range(0, 9) < 4);
      bus.mem_rdata = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/su_fetch_seq.md
SU_FETCH_SEQ -- requirements
Module: su_fetch_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: WAIT cycles without mem_ack before fault (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 run  input  1  level; 1 = sequencer may fetch and execute.
REQ-005 stall  input  1  level; 1 = hold current instruction in EXEC.
REQ-006 mem_ack  input  1  memory returns instruction byte this cycle.
REQ-007 mem_rdata  input  8  instruction byte; sampled only when mem_ack=1 in WAIT.
REQ-008 mem_req  output  1  instruction-read request to memory.
REQ-009 fetch  output  1  to ISA decoder; 1 = INSP-increment fetch cycle.
REQ-010 ce_n  output  1  to ISA decoder; active-low decode enable.
REQ-011 insr  output  8  registered instruction byte to ISA decoder.
REQ-012 busy  output  1  1 in any state other than IDLE.
REQ-013 halted  output  1  sticky; set by HLT instruction.
REQ-014 fault  output  1  sticky; set by fetch timeout.
REQ-015 icount  output  16  retired-instruction counter.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT, EXEC; all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-017 IDLE: fetch=0, ce_n=1, mem_req=0; go FETCH next cycle when run=1, halted=0, fault=0.
REQ-018 FETCH: exactly one cycle; fetch=1, ce_n=0, mem_req=1; always go WAIT.
REQ-019 WAIT: fetch=0, ce_n=1, mem_req=1; on mem_ack=1 load insr<=mem_rdata and go EXEC; run is ignored in WAIT.
REQ-020 EXEC: fetch=0, ce_n=0, mem_req=0, insr stable; remain while stall=1.
REQ-021 EXEC exit (stall=0): icount+1 (wraps 16'hFFFF->16'h0000); insr=8'hFF (HLT) -> set halted, go IDLE; else run=1 -> FETCH; run=0 -> IDLE.
REQ-022 Minimum fetch-to-execute latency 3 cycles: FETCH, WAIT with mem_ack=1, EXEC; back-to-back instruction period 3 cycles with stall=0 and immediate ack.
REQ-023 run deasserted mid-instruction: current instruction completes and retires, then IDLE; no partial abort.
REQ-024 halted clears on the cycle after run is sampled 0 in IDLE; fault clears likewise.
REQ-025 insr retains last value in IDLE; HLT is retired (counted).
REQ-026 mem_ack outside WAIT ignored; no insr update, no state change.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, insr=8'h00, fetch=0, ce_n=1, mem_req=0, busy=0, halted=0, fault=0, icount=16'h0000, timeout counter 0.
REQ-028 Reset mid-WAIT or mid-EXEC abandons the instruction without retiring it; first fetch after release requires run=1 sampled in IDLE.

Configuration
REQ-029 Macro SU_FETCH_TIMEOUT_EN defined: 8-bit wait counter cleared on WAIT entry, incremented each WAIT cycle with mem_ack=0; reaching TIMEOUT_CYC sets fault, drops mem_req, goes IDLE; mem_ack in same cycle as terminal count wins (normal capture).
REQ-030 SU_FETCH_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; fault tied 0.

Verification
REQ-031 Reset release, run=1, mem_ack one cycle after FETCH with 8'h81 -> fetch pulse 1 cycle, insr=8'h81 in EXEC, icount=1 after exit.
REQ-032 Stream 8'h10, 8'hA3, 8'hFF with immediate ack, stall=0 -> three 3-cycle instructions, halted=1, IDLE, icount=3, busy=0.
REQ-033 stall=1 for 4 cycles in EXEC of 8'h05 -> ce_n=0 and insr=8'h05 held 5 cycles, icount incremented once.
REQ-034 run=0 during WAIT, ack after 2 cycles -> instruction executes and retires, then IDLE, no further mem_req.
REQ-035 SU_FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, no ack -> fault=1 after 15 WAIT cycles, mem_req=0; run=0 then 1 -> fault cleared, fetch resumes; undefined build -> mem_req held 100 cycles, fault=0.
REQ-036 rst_n pulsed low in EXEC with icount=16'hFFFF about to wrap -> all REQ-027 values immediately, no wrap observed.
